// File: rtl/frame_scaler_pipe.sv
// Integer upscaler: centres a SRC_W x SRC_H buffer, scaled by SCALE, in a DST_W x DST_H raster.
// Addresses are built incrementally; syncs and window flags follow the frame-buffer read latency.
module frame_scaler_pipe #(
  parameter int          SRC_W      = 320,
  parameter int          SRC_H      = 240,
  parameter int          SCALE      = 2,
  parameter int          DST_W      = 800,
  parameter int          DST_H      = 600,
  parameter int          ADDR_W     = 17,
  parameter int          RD_LAT     = 1,
  parameter logic [11:0] BORDER_RGB = 12'h000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [9:0]        pixel_x,
  input  logic [9:0]        pixel_y,
  input  logic              video_on,
  input  logic              hsync_in,
  input  logic              vsync_in,
  output logic              fb_read_en,
  output logic [ADDR_W-1:0] fb_read_addr,
  input  logic [11:0]       fb_read_data,
  output logic [3:0]        color_r,
  output logic [3:0]        color_g,
  output logic [3:0]        color_b,
  output logic              hsync_out,
  output logic              vsync_out
);

  localparam int WIN_W = SRC_W * SCALE;
  localparam int WIN_H = SRC_H * SCALE;
  localparam int H_OFF = (DST_W - WIN_W) / 2;
  localparam int V_OFF = (DST_H - WIN_H) / 2;
  localparam int SUB_W = (SCALE > 1) ? $clog2(SCALE) : 1;

  localparam logic [9:0]        X_LO     = 10'(H_OFF);
  localparam logic [9:0]        X_HI     = 10'(H_OFF + WIN_W);
  localparam logic [9:0]        Y_LO     = 10'(V_OFF);
  localparam logic [9:0]        Y_HI     = 10'(V_OFF + WIN_H);
  localparam logic [9:0]        X_LAST   = 10'(DST_W - 1);
  localparam logic [9:0]        Y_BLANK  = 10'(DST_H);
  localparam logic [SUB_W-1:0]  SUB_LAST = SUB_W'(SCALE - 1);
  localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(SRC_W);

  if (WIN_W > DST_W || WIN_H > DST_H) begin : g_geom_err
    $error("frame_scaler_pipe: scaled source does not fit the destination raster");
  end
  if (SCALE < 1 || RD_LAT < 1 || RD_LAT > 4) begin : g_param_err
    $error("frame_scaler_pipe: SCALE must be >= 1 and RD_LAT within 1..4");
  end
  if (SRC_W * SRC_H > 2 ** ADDR_W) begin : g_addr_err
    $error("frame_scaler_pipe: ADDR_W too narrow for the source buffer");
  end

  logic              frame_ok_q, frame_ok_d;
  logic [ADDR_W-1:0] row_base_q, row_base_d;
  logic [ADDR_W-1:0] src_x_q, src_x_d;
  logic [SUB_W-1:0]  sub_y_q, sub_y_d;
  logic [SUB_W-1:0]  sub_x_q, sub_x_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              en_q;
  logic [3:0]        tap_q [RD_LAT+1];
  logic [11:0]       color_q, color_d;
  logic              hs_q, vs_q;

  logic x_in, y_in, vid, in_win, row_end;
  logic vid_dly, win_dly, hs_dly, vs_dly;

  // Until a vblank has realigned the vertical counters the picture is held black.
  assign vid     = video_on & frame_ok_q;
  assign x_in    = (pixel_x >= X_LO) && (pixel_x < X_HI);
  assign y_in    = (pixel_y >= Y_LO) && (pixel_y < Y_HI);
  assign in_win  = vid & x_in & y_in;
  assign row_end = vid & y_in & (pixel_x == X_LAST);

  assign {vid_dly, win_dly, hs_dly, vs_dly} = tap_q[RD_LAT];

  always_comb begin
    frame_ok_d = frame_ok_q;
    row_base_d = row_base_q;
    sub_y_d    = sub_y_q;
    if (pixel_y >= Y_BLANK) begin
      frame_ok_d = 1'b1;
      row_base_d = '0;
      sub_y_d    = '0;
    end else if (row_end) begin
      if (sub_y_q == SUB_LAST) begin
        sub_y_d    = '0;
        row_base_d = row_base_q + ROW_STEP;
      end else begin
        sub_y_d = sub_y_q + 1'b1;
      end
    end

    src_x_d = '0;
    sub_x_d = '0;
    if (in_win) begin
      if (sub_x_q == SUB_LAST) begin
        src_x_d = src_x_q + 1'b1;
      end else begin
        src_x_d = src_x_q;
        sub_x_d = sub_x_q + 1'b1;
      end
    end

    addr_d = in_win ? (row_base_q + src_x_q) : '0;

    // Blanking wins over the border colour.
    if (!vid_dly)      color_d = 12'h000;
    else if (win_dly)  color_d = fb_read_data;
    else               color_d = BORDER_RGB;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_ok_q <= 1'b0;
      row_base_q <= '0;
      src_x_q    <= '0;
      sub_y_q    <= '0;
      sub_x_q    <= '0;
      addr_q     <= '0;
      en_q       <= 1'b0;
      color_q    <= '0;
      hs_q       <= 1'b0;
      vs_q       <= 1'b0;
      for (int k = 0; k <= RD_LAT; k++) tap_q[k] <= '0;
    end else begin
      frame_ok_q <= frame_ok_d;
      row_base_q <= row_base_d;
      src_x_q    <= src_x_d;
      sub_y_q    <= sub_y_d;
      sub_x_q    <= sub_x_d;
      addr_q     <= addr_d;
      en_q       <= in_win;
      tap_q[0]   <= {vid, in_win, hsync_in, vsync_in};
      for (int k = 1; k <= RD_LAT; k++) tap_q[k] <= tap_q[k-1];
      color_q    <= color_d;
      hs_q       <= hs_dly;
      vs_q       <= vs_dly;
    end
  end

  assign fb_read_en   = en_q;
  assign fb_read_addr = addr_q;
  assign color_r      = color_q[11:8];
  assign color_g      = color_q[7:4];
  assign color_b      = color_q[3:0];
  assign hsync_out    = hs_q;
  assign vsync_out    = vs_q;

endmodule

// File: tb/tb_frame_scaler_pipe.sv
// Four scaler configurations share one 800x600 raster; a behavioural history of the
// raster inputs predicts every output, with a frame-buffer model answering reads.
module tb_frame_scaler_pipe;

  localparam int N = 4;
  // 0: defaults   1: 256x192 x3   2: defaults, RD_LAT=3, non-zero border   3: 800x600 x1
  localparam int          CFG_SW [N] = '{320, 256, 320, 800};
  localparam int          CFG_SH [N] = '{240, 192, 240, 600};
  localparam int          CFG_SC [N] = '{2, 3, 2, 1};
  localparam int          CFG_LAT[N] = '{1, 1, 3, 1};
  localparam int          CFG_AW [N] = '{17, 17, 17, 19};
  localparam logic [11:0] CFG_BRD[N] = '{12'h000, 12'h000, 12'hA5C, 12'h000};

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       von;
    logic       hs;
    logic       vs;
    logic       ok;
    logic       chk;
  } rec_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [9:0]  px = '0, py = '0;
  logic        von = 1'b0, hs = 1'b0, vs = 1'b0, line_chk = 1'b0;

  logic        en_w [N];
  logic [18:0] addr_w [N];
  logic [11:0] col_w [N];
  logic [11:0] rd_w [N];
  logic        hso_w [N];
  logic        vso_w [N];

  int unsigned seed = 0;
  int          total = 0;
  int          bad = 0;
  bit          chk_on = 1'b0;

  rec_t        hist [8];
  int unsigned pc = 0;
  logic        sync_q = 1'b0;

  always #5 clk = ~clk;

  function automatic logic [11:0] memf(input logic [18:0] a);
    logic [31:0] h;
    h = ({13'b0, a} ^ seed) * 32'h9E3779B1;
    return h[27:16];
  endfunction

  function automatic int hoff(input int i);
    return (800 - CFG_SW[i] * CFG_SC[i]) / 2;
  endfunction

  function automatic int voff(input int i);
    return (600 - CFG_SH[i] * CFG_SC[i]) / 2;
  endfunction

  function automatic bit win_xy(input int i, input int x, input int y);
    return x >= hoff(i) && x < hoff(i) + CFG_SW[i] * CFG_SC[i] &&
           y >= voff(i) && y < voff(i) + CFG_SH[i] * CFG_SC[i];
  endfunction

  function automatic int exp_addr(input int i, input int x, input int y);
    return ((y - voff(i)) / CFG_SC[i]) * CFG_SW[i] + (x - hoff(i)) / CFG_SC[i];
  endfunction

  function automatic bit rec_win(input rec_t r, input int i);
    return r.ok && r.von && win_xy(i, int'(r.x), int'(r.y));
  endfunction

  for (genvar gi = 0; gi < N; gi++) begin : g_dut
    logic [CFG_AW[gi]-1:0] a_loc;
    logic [3:0]            r, g, b;
    logic [11:0]           mp [4];

    frame_scaler_pipe #(
      .SRC_W(CFG_SW[gi]), .SRC_H(CFG_SH[gi]), .SCALE(CFG_SC[gi]),
      .DST_W(800), .DST_H(600), .ADDR_W(CFG_AW[gi]),
      .RD_LAT(CFG_LAT[gi]), .BORDER_RGB(CFG_BRD[gi])
    ) u_dut (
      .clk(clk), .reset_n(reset_n),
      .pixel_x(px), .pixel_y(py), .video_on(von),
      .hsync_in(hs), .vsync_in(vs),
      .fb_read_en(en_w[gi]), .fb_read_addr(a_loc), .fb_read_data(rd_w[gi]),
      .color_r(r), .color_g(g), .color_b(b),
      .hsync_out(hso_w[gi]), .vsync_out(vso_w[gi])
    );

    assign addr_w[gi] = 19'(a_loc);
    assign col_w[gi]  = {r, g, b};

    // Frame buffer: data for an address appears RD_LAT clocks later.
    always @(posedge clk) begin
      mp[0] <= memf(addr_w[gi]);
      for (int k = 1; k < 4; k++) mp[k] <= mp[k-1];
    end
    assign rd_w[gi] = mp[CFG_LAT[gi]-1];
  end

  // Raster history: what the inputs were at each sampling edge, and whether the
  // frame had been realigned by a vblank since the last reset.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= 1'b0;
      for (int k = 0; k < 8; k++) hist[k] <= '0;
    end else begin
      hist[3'(pc + 1)] <= {px, py, von, hs, vs, sync_q, line_chk};
      pc <= pc + 1;
      if (py >= 10'd600) sync_q <= 1'b1;
    end
  end

  task automatic cmp(input string nm, input int i, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s dut%0d t=%0t got=%0h want=%0h", nm, i, $time, got, want);
    end
  endtask

  task automatic check_dut(input int i);
    rec_t        ra, rc;
    bit          wa, wc;
    int          lat;
    logic [11:0] want_col;
    bit          col_known;
    lat = CFG_LAT[i] + 2;
    ra  = hist[3'(pc)];
    rc  = hist[3'(int'(pc) - lat + 1)];
    wa  = rec_win(ra, i);
    wc  = rec_win(rc, i);
    cmp("rd_en", i, 32'(en_w[i]), 32'(wa));
    if (!wa || ra.chk)
      cmp("rd_addr", i, 32'(addr_w[i]), wa ? 32'(exp_addr(i, int'(ra.x), int'(ra.y))) : 32'd0);
    col_known = 1'b1;
    if (!(rc.ok && rc.von))  want_col = 12'h000;
    else if (!wc)            want_col = CFG_BRD[i];
    else if (rc.chk)         want_col = memf(19'(exp_addr(i, int'(rc.x), int'(rc.y))));
    else begin
      want_col  = 12'h000;
      col_known = 1'b0;
    end
    if (col_known) cmp("colour", i, 32'(col_w[i]), 32'(want_col));
    cmp("hsync", i, 32'(hso_w[i]), 32'(rc.hs));
    cmp("vsync", i, 32'(vso_w[i]), 32'(rc.vs));
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      for (int i = 0; i < N; i++) check_dut(i);
    end
  end

  task automatic step(input int x, input int y, input bit v, input bit c);
    @(posedge clk);
    #1;
    px = 10'(x);
    py = 10'(y);
    von = v;
    line_chk = c;
    hs = 1'($urandom_range(0, 1));
    vs = 1'($urandom_range(0, 1));
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    for (int i = 0; i < N; i++) begin
      cmp("rst_en", i, 32'(en_w[i]), 32'd0);
      cmp("rst_addr", i, 32'(addr_w[i]), 32'd0);
      cmp("rst_colour", i, 32'(col_w[i]), 32'd0);
      cmp("rst_sync", i, {30'd0, hso_w[i], vso_w[i]}, 32'd0);
    end
    @(posedge clk);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic full_line(input int y, input bit rst_here);
    int nb;
    nb = $urandom_range(1, 3);
    for (int k = 0; k < nb; k++) step(800 + k, y, 1'b0, 1'b0);
    for (int x = 0; x < 800; x++) begin
      step(x, y, 1'b1, 1'b1);
      if (rst_here && x == 400) do_reset();
    end
  endtask

  task automatic skip_line(input int y);
    step(799, y, 1'b1, 1'b0);
    step(800, y, 1'b0, 1'b0);
  endtask

  task automatic vblank();
    for (int k = 0; k < 6; k++) step(k, 600 + k, 1'b0, 1'b0);
  endtask

  task automatic run_frame(input int fi);
    for (int y = 0; y < 600; y++) begin
      if (y inside {0, 12, 14, 15, 24, 59, 60, 61, 62, 299, 300, 301, 538, 539, 587, 588, 599} ||
          $urandom_range(0, 99) == 0)
        full_line(y, fi == 1 && y == 300);
      else
        skip_line(y);
    end
    vblank();
  endtask

  // Hand-computed anchors for the address and window model.
  localparam int PIN_N = 10;
  localparam int PIN_I[PIN_N] = '{0, 0, 0, 0, 1, 1, 1, 1, 3, 3};
  localparam int PIN_X[PIN_N] = '{80, 81, 82, 719, 16, 18, 19, 16, 799, 5};
  localparam int PIN_Y[PIN_N] = '{60, 60, 60, 539, 12, 14, 12, 24, 599, 7};
  localparam int PIN_A[PIN_N] = '{0, 0, 1, 76799, 0, 0, 1, 1024, 479999, 5605};
  localparam int WP_N = 6;
  localparam int WP_I[WP_N] = '{0, 0, 0, 0, 1, 1};
  localparam int WP_X[WP_N] = '{79, 720, 80, 80, 15, 16};
  localparam int WP_Y[WP_N] = '{60, 60, 59, 60, 12, 12};
  localparam int WP_W[WP_N] = '{0, 0, 0, 1, 0, 1};

  initial begin
    seed = $urandom;
    for (int k = 0; k < PIN_N; k++)
      cmp("model_addr", PIN_I[k], 32'(exp_addr(PIN_I[k], PIN_X[k], PIN_Y[k])), 32'(PIN_A[k]));
    for (int k = 0; k < WP_N; k++)
      cmp("model_win", WP_I[k], 32'(win_xy(WP_I[k], WP_X[k], WP_Y[k])), 32'(WP_W[k]));
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    chk_on = 1'b1;
    vblank();
    run_frame(0);
    run_frame(1);
    run_frame(2);
    for (int k = 0; k < 8; k++) step(800, 0, 1'b0, 1'b0);
    chk_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not complete, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
